// File: rtl/pl_reg_file_pkg.sv
// +--------------------------------------------------------------------+
// | pl_reg_file_pkg : core-wide register-file widths, indices, types    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package pl_reg_file_pkg;

  localparam int W    = 32;
  localparam int AW   = 5;
  localparam int NREG = 2 ** AW;

  typedef logic [AW-1:0] reg_idx_t;
  typedef logic [W-1:0]  word_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_A0   = 5'd10;

endpackage

`default_nettype wire

// File: rtl/pl_reg_file_if.sv
// +--------------------------------------------------------------------+
// | pl_reg_file_if : write-back write port, decode read ports, a0 tap  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface pl_reg_file_if;
  import pl_reg_file_pkg::*;

  logic     RegWrite;
  reg_idx_t rd;
  word_t    DInReg;
  reg_idx_t rs1;
  reg_idx_t rs2;
  word_t    RD1;
  word_t    RD2;
  word_t    a0;

  modport master (
    output RegWrite, rd, DInReg, rs1, rs2,
    input  RD1, RD2, a0
  );

  modport slave (
    input  RegWrite, rd, DInReg, rs1, rs2,
    output RD1, RD2, a0
  );

endinterface

`default_nettype wire

// File: rtl/pl_reg_file.sv
// +--------------------------------------------------------------------+
// | pl_reg_file : 32-entry integer register file, 2R/1W, WB->ID bypass |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module pl_reg_file
  import pl_reg_file_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  pl_reg_file_if.slave  rf_bus
);

  word_t regs_q [NREG];
  logic  wr_en;

  // Reset also kills the bypass, so RD1/RD2 read zero while rst is high.
  assign wr_en = rf_bus.RegWrite && !rst;

  function automatic word_t read_port(
    input reg_idx_t ra,
    input logic     we,
    input reg_idx_t wa,
    input word_t    wd,
    input word_t    stored
  );
    if (ra == REG_ZERO)
      return '0;
    else if (we && (wa == ra))
      return wd;
    else
      return stored;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else if (rf_bus.RegWrite && (rf_bus.rd != REG_ZERO)) begin
      regs_q[rf_bus.rd] <= rf_bus.DInReg;
    end
  end

  assign rf_bus.RD1 = read_port(rf_bus.rs1, wr_en, rf_bus.rd, rf_bus.DInReg, regs_q[rf_bus.rs1]);
  assign rf_bus.RD2 = read_port(rf_bus.rs2, wr_en, rf_bus.rd, rf_bus.DInReg, regs_q[rf_bus.rs2]);
  assign rf_bus.a0  = regs_q[REG_A0];

endmodule

`default_nettype wire

// File: tb/tb_pl_reg_file.sv
// +--------------------------------------------------------------------+
// | tb_pl_reg_file : directed self-checking bench for pl_reg_file      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_pl_reg_file;
  import pl_reg_file_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pl_reg_file_if bus ();

  pl_reg_file u_dut (
    .clk    (clk),
    .rst    (rst),
    .rf_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One registered write; inputs change on the falling edge.
  task automatic wr(input reg_idx_t a, input word_t d);
    @(negedge clk);
    bus.RegWrite = 1'b1;
    bus.rd       = a;
    bus.DInReg   = d;
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    bus.RegWrite = 1'b0;
    bus.rd       = '0;
    bus.DInReg   = '0;
    bus.rs1      = '0;
    bus.rs2      = '0;

    #2 rst = 1'b1;
    bus.rs1 = 5'd5;
    #1;
    check("reset_rd1", bus.RD1, 32'h0);
    check("reset_a0",  bus.a0,  32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset between edges clears stored state
    wr(5'd5,  32'h0000_1234);
    wr(5'd10, 32'h0000_CAFE);
    bus.rs1 = 5'd5;
    #1;
    check("pre_rst_x5", bus.RD1, 32'h0000_1234);
    check("pre_rst_a0", bus.a0,  32'h0000_CAFE);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_x5", bus.RD1, 32'h0);
    check("async_rst_a0", bus.a0,  32'h0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_x5", bus.RD1, 32'h0);
    check("post_rst_a0", bus.a0,  32'h0);

    // Basic write then read on both ports
    wr(5'd7, 32'hDEAD_BEEF);
    bus.rs1 = 5'd7;
    bus.rs2 = 5'd7;
    #1;
    check("x7_rd1", bus.RD1, 32'hDEAD_BEEF);
    check("x7_rd2", bus.RD2, 32'hDEAD_BEEF);

    // x0 is hardwired to zero, even while being written
    @(negedge clk);
    bus.RegWrite = 1'b1;
    bus.rd       = 5'd0;
    bus.DInReg   = 32'hFFFF_FFFF;
    bus.rs1      = 5'd0;
    bus.rs2      = 5'd7;
    #1;
    check("x0_same_cycle", bus.RD1, 32'h0);
    check("x0_x7_same",    bus.RD2, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    #1;
    check("x0_after_edge", bus.RD1, 32'h0);
    check("x0_x7_after",   bus.RD2, 32'hDEAD_BEEF);

    // Bypass on one port while the other reads storage
    wr(5'd3, 32'h11);
    wr(5'd4, 32'h44);
    @(negedge clk);
    bus.RegWrite = 1'b1;
    bus.rd       = 5'd3;
    bus.DInReg   = 32'h22;
    bus.rs1      = 5'd3;
    bus.rs2      = 5'd4;
    #1;
    check("byp_rd1", bus.RD1, 32'h22);
    check("byp_rd2", bus.RD2, 32'h44);
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    #1;
    check("byp_x3_stored", bus.RD1, 32'h22);

    // Dual bypass to x10; a0 shows only the stored value
    wr(5'd10, 32'h1111);
    @(negedge clk);
    bus.RegWrite = 1'b1;
    bus.rd       = 5'd10;
    bus.DInReg   = 32'h5A5A;
    bus.rs1      = 5'd10;
    bus.rs2      = 5'd10;
    #1;
    check("a0_byp_rd1", bus.RD1, 32'h5A5A);
    check("a0_byp_rd2", bus.RD2, 32'h5A5A);
    check("a0_old",     bus.a0,  32'h1111);
    @(posedge clk);
    #1;
    check("a0_new",     bus.a0,  32'h5A5A);

    // Back-to-back writes to the same register: last edge wins
    @(negedge clk);
    bus.DInReg = 32'h0000_0001;
    @(negedge clk);
    bus.DInReg = 32'h0000_0002;
    #1;
    check("b2b_bypass", bus.RD1, 32'h0000_0002);
    check("b2b_a0_mid", bus.a0,  32'h0000_0001);
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    #1;
    check("b2b_a0_last", bus.a0, 32'h0000_0002);

    // Write attempted while reset is held is discarded
    @(negedge clk);
    rst          = 1'b1;
    bus.RegWrite = 1'b1;
    bus.rd       = 5'd9;
    bus.DInReg   = 32'h99;
    bus.rs1      = 5'd9;
    bus.rs2      = 5'd7;
    #1;
    check("rstwr_byp_off", bus.RD1, 32'h0);
    check("rstwr_x7_clr",  bus.RD2, 32'h0);
    @(posedge clk);
    #1;
    check("rstwr_edge", bus.RD1, 32'h0);
    bus.RegWrite = 1'b0;
    rst          = 1'b0;
    #1;
    check("rstwr_x9_after", bus.RD1, 32'h0);
    check("rstwr_a0_after", bus.a0,  32'h0);

    // First write after reset release lands on the next edge
    wr(5'd9, 32'h0000_0909);
    #1;
    check("post_rel_x9", bus.RD1, 32'h0000_0909);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
